// File: rtl/gardner_timing_loop_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : gardner_timing_loop_if                                |
// | Timing-error handshake between the Gardner TED and timing loop.  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface gardner_timing_loop_if #(
    parameter int ERROR_LENGTH_BITS = 25
);
    logic signed [ERROR_LENGTH_BITS-1:0] err;
    logic                                err_valid;
    logic                                err_ready;

    modport master (output err, output err_valid, input err_ready);
    modport slave  (input err, input err_valid, output err_ready);
endinterface
`default_nettype wire

// File: rtl/gardner_timing_loop.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : gardner_timing_loop                                   |
// | PI loop filter + phase-accumulator NCO closing the Gardner symbol |
// | timing loop. Optional freeze input: GARDNER_TIMING_LOOP_FREEZE_EN.|
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module gardner_timing_loop #(
    parameter int SAMPLES_PER_SYMBOL = 4,
    parameter int ERROR_LENGTH_BITS  = 25,
    parameter int PHASE_LENGTH_BITS  = 16,
    parameter int ACCUM_LENGTH_BITS  = 32,
    parameter int KP_SHIFT           = 8,
    parameter int KI_SHIFT           = 16,
    parameter int LOCK_THRESHOLD     = 1024,
    parameter int LOCK_COUNT         = 8
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    gardner_timing_loop_if.slave              err_if,
    input  wire logic                         sample_valid,
    output logic                              trigger,
    output logic [PHASE_LENGTH_BITS-1:0]      phase,
    output logic                              locked
`ifdef GARDNER_TIMING_LOOP_FREEZE_EN
    ,
    input  wire logic                         freeze
`endif
);
    localparam int EB  = ERROR_LENGTH_BITS;
    localparam int PB  = PHASE_LENGTH_BITS;
    localparam int AB  = ACCUM_LENGTH_BITS;
    localparam int SW  = ACCUM_LENGTH_BITS + 2;
    localparam int LCW = $clog2(LOCK_COUNT + 1);

    localparam logic [PB-1:0]        INC_NOM   = PB'((1 << PB) / SAMPLES_PER_SYMBOL);
    localparam logic [PB-1:0]        INC_MIN   = INC_NOM >> 1;
    localparam logic [PB-1:0]        INC_MAX   = INC_NOM + (INC_NOM >> 1);
    localparam logic signed [SW-1:0] INC_MIN_W = {{(SW-PB){1'b0}}, INC_MIN};
    localparam logic signed [SW-1:0] INC_MAX_W = {{(SW-PB){1'b0}}, INC_MAX};
    localparam logic signed [AB-1:0] INTEG_MAX = {1'b0, {(AB-1){1'b1}}};
    localparam logic signed [AB-1:0] INTEG_MIN = {1'b1, {(AB-1){1'b0}}};
    localparam logic [EB-1:0]        THRESH    = EB'(LOCK_THRESHOLD);
    localparam logic [LCW-1:0]       LOCK_FULL = LCW'(LOCK_COUNT);

    logic                   ready;
    logic [PB-1:0]          inc;
    logic signed [AB-1:0]   integ;
    logic [LCW-1:0]         lock_cnt;

    logic                   accept;
    logic                   update;
    logic signed [EB-1:0]   p_next;
    logic signed [EB-1:0]   i_step;
    logic signed [AB:0]     integ_sum;
    logic signed [AB-1:0]   integ_next;
    logic signed [SW-1:0]   inc_sum;
    logic [PB-1:0]          inc_next;
    logic [PB:0]            phase_sum;
    logic [EB-1:0]          err_mag;
    logic                   err_is_min;
    logic                   in_lock;
    logic [LCW-1:0]         lock_next;

    assign err_if.err_ready = ready;

    always_comb begin
        accept = err_if.err_valid & ready;
        update = accept;
`ifdef GARDNER_TIMING_LOOP_FREEZE_EN
        update = accept & ~freeze;
`endif
        p_next    = err_if.err >>> KP_SHIFT;
        i_step    = err_if.err >>> KI_SHIFT;
        integ_sum = {integ[AB-1], integ} + {{(AB+1-EB){i_step[EB-1]}}, i_step};
        if (integ_sum[AB] != integ_sum[AB-1]) begin
            integ_next = integ_sum[AB] ? INTEG_MIN : INTEG_MAX;
        end else begin
            integ_next = integ_sum[AB-1:0];
        end

        // Wide enough that nominal + proportional + integral never wraps before the clamp.
        inc_sum = {{(SW-PB){1'b0}}, INC_NOM}
                + {{(SW-EB){p_next[EB-1]}}, p_next}
                + {{(SW-AB){integ_next[AB-1]}}, integ_next};
        if (inc_sum < INC_MIN_W) begin
            inc_next = INC_MIN;
        end else if (inc_sum > INC_MAX_W) begin
            inc_next = INC_MAX;
        end else begin
            inc_next = inc_sum[PB-1:0];
        end

        phase_sum = {1'b0, phase} + {1'b0, inc};

        // The most negative error has no positive magnitude, so it never counts as in lock.
        err_is_min = err_if.err[EB-1] & ~|err_if.err[EB-2:0];
        err_mag    = err_if.err[EB-1] ? $unsigned(-err_if.err) : $unsigned(err_if.err);
        in_lock    = ~err_is_min & (err_mag < THRESH);
        if (!in_lock) begin
            lock_next = '0;
        end else if (lock_cnt == LOCK_FULL) begin
            lock_next = LOCK_FULL;
        end else begin
            lock_next = lock_cnt + LCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready    <= 1'b0;
            phase    <= '0;
            trigger  <= 1'b0;
            inc      <= INC_NOM;
            integ    <= '0;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            ready <= 1'b1;
            if (sample_valid) begin
                phase   <= phase_sum[PB-1:0];
                trigger <= phase_sum[PB];
            end
            if (update) begin
                integ    <= integ_next;
                inc      <= inc_next;
                lock_cnt <= lock_next;
                locked   <= (lock_next == LOCK_FULL);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gardner_timing_loop.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_gardner_timing_loop                                |
// | Directed + randomized bench for gardner_timing_loop.              |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_gardner_timing_loop;
    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic        trigger;
    logic [15:0] phase;
    logic        locked;
`ifdef GARDNER_TIMING_LOOP_FREEZE_EN
    logic        freeze;
`endif

    int tests = 0;
    int fails = 0;

    longint m_phase, m_inc, m_integ;
    int     m_lock;
    bit     m_trig, m_locked, m_ready, m_freeze;

    always #5 clk = ~clk;

    gardner_timing_loop_if #(.ERROR_LENGTH_BITS(25)) bus ();

    gardner_timing_loop dut (
        .clk          (clk),
        .rst          (rst),
        .err_if       (bus),
        .sample_valid (sample_valid),
        .trigger      (trigger),
        .phase        (phase),
        .locked       (locked)
`ifdef GARDNER_TIMING_LOOP_FREEZE_EN
        ,
        .freeze       (freeze)
`endif
    );

    // floor(v / 2^k), i.e. what an arithmetic right shift means numerically
    function automatic longint floor_div_pow2(input longint v, input int k);
        longint d;
        d = longint'(1) << k;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_inc = 16384; m_integ = 0; m_lock = 0;
        m_trig = 0; m_locked = 0; m_ready = 0;
    endtask

    task automatic model_edge(input bit sv, input bit ev, input longint e);
        longint s, p, ig, tgt, mag, imax, imin;
        imax = (longint'(1) << 31) - 1;
        imin = -(longint'(1) << 31);
        if (sv) begin
            s = m_phase + m_inc;
            m_trig = (s >= 65536);
            m_phase = s % 65536;
        end
        if (ev && m_ready && !m_freeze) begin
            p  = floor_div_pow2(e, 8);
            ig = m_integ + floor_div_pow2(e, 16);
            if (ig > imax) ig = imax;
            if (ig < imin) ig = imin;
            m_integ = ig;
            tgt = 16384 + p + ig;
            m_inc = (tgt < 8192) ? 8192 : (tgt > 24576) ? 24576 : tgt;
            mag = (e < 0) ? -e : e;
            if (e != -16777216 && mag < 1024) m_lock = (m_lock >= 8) ? 8 : m_lock + 1;
            else m_lock = 0;
            m_locked = (m_lock == 8);
        end
        m_ready = 1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("phase",     longint'(phase), m_phase);
        chk("trigger",   longint'(trigger), longint'(m_trig));
        chk("locked",    longint'(locked), longint'(m_locked));
        chk("err_ready", longint'(bus.err_ready), longint'(m_ready));
        chk("inc",       longint'(dut.inc), m_inc);
        chk("lock_cnt",  longint'(dut.lock_cnt), longint'(m_lock));
    endtask

    task automatic cycle(input bit sv, input bit ev, input longint e);
        sample_valid  = sv;
        bus.err_valid = ev;
        bus.err       = 25'(e);
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(sv, ev, e);
        #1 check_all();
    endtask

    function automatic longint rand_err();
        logic signed [24:0] r;
        int sel;
        sel = int'($urandom_range(0, 3));
        r = 25'($urandom);
        case (sel)
            0: return longint'($urandom_range(0, 2999)) - 1500;
            1: return r;
            2: return -16777216;
            default: return longint'($urandom_range(0, 131071)) - 65536;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        bus.err_valid = 1'b0;
        bus.err = '0;
`ifdef GARDNER_TIMING_LOOP_FREEZE_EN
        freeze = 1'b0;
`endif
        m_freeze = 0;
        model_reset();

        repeat (1000) cycle(1, 1, 5000);
        chk("reset_phase_zero", longint'(phase), 0);
        rst = 1'b0;

        // Free run: wrap every fourth sample
        repeat (4) cycle(1, 0, 0);
        chk("freerun_wrap_phase", longint'(phase), 0);
        chk("freerun_wrap_trig", longint'(trigger), 1);
        repeat (8) cycle(1, 0, 0);

        // Gap right after a wrap: trigger waits for the next sample
        repeat (10) cycle(0, 0, 0);
        chk("gap_trigger_held", longint'(trigger), 1);
        cycle(1, 0, 0);
        chk("gap_trigger_clear", longint'(trigger), 0);

        cycle(0, 1, 2560);
        chk("gain_p_only", longint'(dut.inc), 16394);
        repeat (10) cycle(0, 1, 65536);
        chk("gain_p_and_i", longint'(dut.inc), 16650);

        repeat (8) cycle(0, 1, 100);
        chk("lock_set", longint'(locked), 1);
        cycle(0, 1, 5000);
        chk("lock_drop", longint'(locked), 0);

`ifdef GARDNER_TIMING_LOOP_FREEZE_EN
        repeat (8) cycle(1, 1, 100);
        freeze = 1'b1; m_freeze = 1;
        cycle(1, 1, 5000);
        chk("freeze_hold_lock", longint'(locked), 1);
        freeze = 1'b0; m_freeze = 0;
`endif

        repeat (4) cycle(1, 1, 16777215);
        chk("clamp_high", longint'(dut.inc), 24576);
        repeat (4) cycle(1, 1, -16777216);
        chk("clamp_low", longint'(dut.inc), 8192);

        for (int i = 0; i < 400; i++) begin
`ifdef GARDNER_TIMING_LOOP_FREEZE_EN
            freeze = ($urandom_range(0, 7) == 0);
            m_freeze = freeze;
`endif
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_err());
        end

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        repeat (3) cycle(1, 1, 3000);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_err());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
